alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational `alu` instance between two requesters, for example the PC-increment path and the execute stage. It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands and captures the result. It returns the result to the winning requester over a valid/ready response handshake. It also rejects function codes the ALU does not implement, so the ALU's hold-previous-value behaviour on unknown codes never reaches a requester.

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef INST_FUNC_ADD
`define INST_FUNC_ADD 6'h00
`define INST_FUNC_SUB 6'h01
`define INST_FUNC_NOT 6'h02
`define INST_FUNC_AND 6'h03
`define INST_FUNC_ORR 6'h04
`define INST_FUNC_TCP 6'h05
`define INST_FUNC_SHL 6'h06
`define INST_FUNC_SHR 6'h07
`endif

module alu_arbiter #(
    parameter int unsigned WIDTH = `WORD_SIZE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [5:0]       req0_func,
    input  logic [5:0]       req1_func,
    input  logic [WIDTH-1:0] req0_data_1,
    input  logic [WIDTH-1:0] req1_data_1,
    input  logic [WIDTH-1:0] req0_data_2,
    input  logic [WIDTH-1:0] req1_data_2,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_err,
    output logic [5:0]       alu_func,
    output logic [WIDTH-1:0] alu_data_1,
    output logic [WIDTH-1:0] alu_data_2,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             err_q, err_d;
    logic [5:0]       alu_func_q, alu_func_d;
    logic [WIDTH-1:0] alu_data_1_q, alu_data_1_d;
    logic [WIDTH-1:0] alu_data_2_q, alu_data_2_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             grant0, grant1;
    logic [5:0]       sel_func;
    logic [WIDTH-1:0] sel_data_1, sel_data_2;
    logic             func_ok;

`ifdef ALU_ARB_RR_EN
    // last_q is the most recently granted port; it loses the next conflict.
    logic last_q, last_d;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
        last_d = last_q;
        if (state_q == StIdle && (grant0 || grant1)) begin
            last_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign sel_func   = grant1 ? req1_func   : req0_func;
    assign sel_data_1 = grant1 ? req1_data_1 : req0_data_1;
    assign sel_data_2 = grant1 ? req1_data_2 : req0_data_2;
    assign func_ok    = sel_func inside {`INST_FUNC_ADD, `INST_FUNC_SUB, `INST_FUNC_NOT,
                                         `INST_FUNC_AND, `INST_FUNC_ORR, `INST_FUNC_TCP,
                                         `INST_FUNC_SHL, `INST_FUNC_SHR};

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        err_d        = err_q;
        alu_func_d   = alu_func_q;
        alu_data_1_d = alu_data_1_q;
        alu_data_2_d = alu_data_2_q;
        result_d     = result_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    state_d      = StExec;
                    owner_d      = grant1;
                    err_d        = !func_ok;
                    alu_func_d   = sel_func;
                    alu_data_1_d = sel_data_1;
                    alu_data_2_d = sel_data_2;
                end
            end
            StExec: begin
                // Unsupported codes must never leak the ALU's held value.
                result_d = err_q ? '0 : alu_result;
                state_d  = StResp;
            end
            StResp: begin
                if (owner_q ? resp1_ready : resp0_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            alu_func_q   <= '0;
            alu_data_1_q <= '0;
            alu_data_2_q <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            alu_func_q   <= alu_func_d;
            alu_data_1_q <= alu_data_1_d;
            alu_data_2_q <= alu_data_2_d;
            result_q     <= result_d;
        end
    end

    // Gated with reset_n so ready drops immediately when reset is asserted.
    assign req0_ready  = reset_n && (state_q == StIdle) && grant0;
    assign req1_ready  = reset_n && (state_q == StIdle) && grant1;
    assign resp0_valid = (state_q == StResp) && !owner_q;
    assign resp1_valid = (state_q == StResp) && owner_q;
    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign alu_func    = alu_func_q;
    assign alu_data_1  = alu_data_1_q;
    assign alu_data_2  = alu_data_2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: stub ALU plus a behavioural model of
// results, error flag and arbitration order.

module tb_alu_arbiter;

    localparam logic [5:0] F_ADD = 6'h00, F_SUB = 6'h01, F_NOT = 6'h02, F_AND = 6'h03;
    localparam logic [5:0] F_ORR = 6'h04, F_TCP = 6'h05, F_SHL = 6'h06, F_SHR = 6'h07;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [5:0]  req0_func = '0, req1_func = '0;
    logic [15:0] req0_data_1 = '0, req1_data_1 = '0, req0_data_2 = '0, req1_data_2 = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [15:0] resp_result;
    logic        resp_err;
    logic [5:0]  alu_func;
    logic [15:0] alu_data_1, alu_data_2, alu_result;

    int n_checks = 0;
    int n_errors = 0;
    int m_last = 1;  // model: most recently granted port

    alu_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_func(req0_func), .req1_func(req1_func),
        .req0_data_1(req0_data_1), .req1_data_1(req1_data_1),
        .req0_data_2(req0_data_2), .req1_data_2(req1_data_2),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_err(resp_err),
        .alu_func(alu_func), .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Stub ALU; unknown codes give a marker value that must never reach a requester.
    always_comb begin
        case (alu_func)
            F_ADD:   alu_result = alu_data_1 + alu_data_2;
            F_SUB:   alu_result = alu_data_1 - alu_data_2;
            F_NOT:   alu_result = ~alu_data_1;
            F_AND:   alu_result = alu_data_1 & alu_data_2;
            F_ORR:   alu_result = alu_data_1 | alu_data_2;
            F_TCP:   alu_result = -alu_data_1;
            F_SHL:   alu_result = alu_data_1 << 1;
            F_SHR:   alu_result = alu_data_1 >> 1;
            default: alu_result = 16'hDEAD;
        endcase
    end

    function automatic logic [15:0] ref_result(input logic [5:0] f, input logic [15:0] a,
                                               input logic [15:0] b);
        int unsigned x, y, r;
        x = a;
        y = b;
        case (f)
            F_ADD:   r = (x + y) % 65536;
            F_SUB:   r = (x + 65536 - y) % 65536;
            F_NOT:   r = 65535 - x;
            F_AND:   r = x & y;
            F_ORR:   r = x | y;
            F_TCP:   r = (65536 - x) % 65536;
            F_SHL:   r = (x * 2) % 65536;
            F_SHR:   r = x / 2;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic logic ref_err(input logic [5:0] f);
        return !(f inside {F_ADD, F_SUB, F_NOT, F_AND, F_ORR, F_TCP, F_SHL, F_SHR});
    endfunction

    function automatic int ref_winner(input logic v0, input logic v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef ALU_ARB_RR_EN
        return 1 - m_last;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int port, input logic v, input logic [5:0] f,
                             input logic [15:0] a, input logic [15:0] b);
        if (port == 0) begin
            req0_valid = v; req0_func = f; req0_data_1 = a; req0_data_2 = b;
        end else begin
            req1_valid = v; req1_func = f; req1_data_1 = a; req1_data_2 = b;
        end
    endtask

    task automatic do_reset();
        drive_req(0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, '0, '0, '0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        m_last = 1;
    endtask

    // Full transaction on one port: waits for accept, then for the response, then takes it.
    task automatic issue_op(input int port, input logic [5:0] f, input logic [15:0] a,
                            input logic [15:0] b, output logic [15:0] res, output logic err,
                            output int wait_n, output int lat, output bit tmo);
        res = '0; err = 1'b0; tmo = 1'b0; wait_n = 0; lat = 1;
        drive_req(port, 1'b1, f, a, b);
        forever begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) break;
            wait_n++;
            if (wait_n > 30) begin tmo = 1'b1; break; end
            tick();
        end
        tick();
        drive_req(port, 1'b0, f, a, b);
        if (tmo) return;
        m_last = port;
        forever begin
            @(negedge clk);
            if ((port == 0) ? resp0_valid : resp1_valid) break;
            lat++;
            if (lat > 30) begin tmo = 1'b1; return; end
            tick();
        end
        res = resp_result;
        err = resp_err;
        if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, resp_result,
             alu_func, alu_data_1, alu_data_2} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b err=%b res=%h alu=%h/%h/%h, want 0",
                     req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, resp_result,
                     alu_func, alu_data_1, alu_data_2);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [15:0] res; logic err; int w, l; bit tmo;
        issue_op(0, F_ADD, 16'h0003, 16'h0004, res, err, w, l, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin n_errors++; $display("FAIL single_timeout: timed out"); end
        n_checks++;
        if (w != 0) begin n_errors++; $display("FAIL single_accept: waited %0d want 0", w); end
        n_checks++;
        if (l != 2) begin n_errors++; $display("FAIL single_latency: got %0d want 2", l); end
        n_checks++;
        if (res !== 16'h0007) begin
            n_errors++; $display("FAIL single_result: got %h want 0007", res);
        end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        logic [15:0] a0, b0;
        a0 = 16'($urandom);
        b0 = 16'($urandom);
        drive_req(1, 1'b1, F_SUB, 16'h0001, 16'h0002);
        @(negedge clk);
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_errors++; $display("FAIL bp_accept: req1_ready=%b want 1", req1_ready);
        end
        tick();
        drive_req(1, 1'b0, F_SUB, 16'h0001, 16'h0002);
        m_last = 1;
        drive_req(0, 1'b1, F_AND, a0, b0);
        @(negedge clk);
        n_checks++;
        if ({req0_ready, resp0_valid, resp1_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL bp_exec: rdy0=%b vld=%b%b want 000", req0_ready, resp0_valid, resp1_valid);
        end
        for (int i = 0; i < 5; i++) begin
            resp0_ready = (i < 4);  // wrong-port ready must be ignored
            tick();
            @(negedge clk);
            n_checks++;
            if ({resp1_valid, resp0_valid, req0_ready, resp_err, resp_result} !==
                {4'b1000, 16'hFFFF}) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: vld1=%b vld0=%b rdy0=%b err=%b res=%h want 1000 FFFF",
                         i, resp1_valid, resp0_valid, req0_ready, resp_err, resp_result);
            end
            if (i == 4) begin resp0_ready = 1'b0; resp1_ready = 1'b1; end
        end
        tick();
        resp1_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, resp1_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL bp_next_accept: rdy0=%b vld1=%b want 1 0", req0_ready, resp1_valid);
        end
        tick();
        drive_req(0, 1'b0, F_AND, a0, b0);
        m_last = 0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({resp0_valid, resp_err, resp_result} !== {2'b10, ref_result(F_AND, a0, b0)}) begin
            n_errors++;
            $display("FAIL bp_port0_result: vld0=%b err=%b res=%h want 1 0 %h",
                     resp0_valid, resp_err, resp_result, ref_result(F_AND, a0, b0));
        end
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
    endtask

    task automatic test_conflict();
        logic [5:0] cf [2];
        logic [15:0] ca [2], cb [2];
        int cnt [2];
        bit upd [2];
        int exp_port [$];
        logic [15:0] exp_res [$];
        logic exp_e [$];
        int done, last_acc, p, ep;
        logic v0, v1;
        do_reset();
        done = 0; last_acc = -1;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; upd[k] = 1'b0;
            cf[k] = 6'($urandom_range(0, 7)); ca[k] = 16'($urandom); cb[k] = 16'($urandom);
            drive_req(k, 1'b1, cf[k], ca[k], cb[k]);
        end
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && done < 8; cyc++) begin
            @(negedge clk);
            v0 = req0_valid;
            v1 = req1_valid;
            if ((resp0_valid || resp1_valid) && exp_port.size() > 0) begin
                ep = exp_port.pop_front();
                n_checks++;
                if ({resp1_valid, resp0_valid, resp_err, resp_result} !==
                    {(ep == 1), (ep == 0), exp_e.pop_front(), exp_res.pop_front()}) begin
                    n_errors++;
                    $display("FAIL conflict_resp: vld=%b%b err=%b res=%h for port %0d",
                             resp1_valid, resp0_valid, resp_err, resp_result, ep);
                end
                done++;
            end
            if (req0_ready || req1_ready) begin
                p = req1_ready ? 1 : 0;
                n_checks++;
                if ((req0_ready && req1_ready) || p != ref_winner(v0, v1)) begin
                    n_errors++;
                    $display("FAIL conflict_grant: rdy=%b%b want port %0d", req1_ready,
                             req0_ready, ref_winner(v0, v1));
                end
                m_last = p;
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != 3) begin
                        n_errors++;
                        $display("FAIL conflict_spacing: got %0d cycles want 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                exp_port.push_back(p);
                exp_res.push_back(ref_result(cf[p], ca[p], cb[p]));
                exp_e.push_back(ref_err(cf[p]));
                cnt[p]++;
                upd[p] = 1'b1;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (upd[k]) begin
                    upd[k] = 1'b0;
                    cf[k] = 6'($urandom_range(0, 7)); ca[k] = 16'($urandom);
                    cb[k] = 16'($urandom);
                    drive_req(k, cnt[k] < 4, cf[k], ca[k], cb[k]);
                end
            end
        end
        n_checks++;
        if (done != 8) begin n_errors++; $display("FAIL conflict_done: got %0d want 8", done); end
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic test_bad_func();
        logic [15:0] res; logic err; int w, l; bit tmo;
        issue_op(0, 6'h3F, 16'($urandom), 16'($urandom), res, err, w, l, tmo);
        n_checks++;
        if ({tmo, err, res} !== {2'b01, 16'h0000}) begin
            n_errors++; $display("FAIL bad_func: tmo=%b err=%b res=%h want 0 1 0000", tmo, err, res);
        end
        issue_op(0, F_TCP, 16'h0005, 16'h0000, res, err, w, l, tmo);
        n_checks++;
        if ({tmo, err, res} !== {2'b00, 16'hFFFB}) begin
            n_errors++; $display("FAIL after_bad: tmo=%b err=%b res=%h want 0 0 FFFB", tmo, err, res);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] res; logic err; int w, l, seen; bit tmo;
        drive_req(0, 1'b1, F_SHL, 16'h1234, 16'h5678);
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_mid_accept: rdy0=%b want 1", req0_ready);
        end
        tick();
        drive_req(0, 1'b0, F_SHL, 16'h1234, 16'h5678);
        req1_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, resp_result,
             alu_func, alu_data_1, alu_data_2} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: rdy=%b%b vld=%b%b res=%h alu=%h/%h/%h want 0",
                     req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result,
                     alu_func, alu_data_1, alu_data_2);
        end
        tick();
        tick();
        reset_n = 1'b1;
        m_last = 1;
        req1_valid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL rst_mid_stray: %0d valid cycles", seen); end
        req1_valid = 1'b1;
        issue_op(0, F_ADD, 16'h0100, 16'h0020, res, err, w, l, tmo);
        req1_valid = 1'b0;
        n_checks++;
        if (tmo || w != 0 || l != 2 || res !== 16'h0120 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_first: wait=%0d lat=%0d res=%h err=%b want 0 2 0120 0",
                     w, l, res, err);
        end
    endtask

    task automatic test_shift_logic();
        logic [15:0] res; logic err; int w, l; bit tmo;
        issue_op(1, F_SHL, 16'h8001, 16'h0000, res, err, w, l, tmo);
        n_checks++;
        if ({tmo, err, res} !== {2'b00, 16'h0002}) begin
            n_errors++; $display("FAIL shl: res=%h err=%b want 0002 0", res, err);
        end
        issue_op(1, F_SHR, 16'h8001, 16'h0000, res, err, w, l, tmo);
        n_checks++;
        if ({tmo, err, res} !== {2'b00, 16'h4000}) begin
            n_errors++; $display("FAIL shr: res=%h err=%b want 4000 0", res, err);
        end
        issue_op(0, F_NOT, 16'h00FF, 16'h0000, res, err, w, l, tmo);
        n_checks++;
        if ({tmo, err, res} !== {2'b00, 16'hFF00}) begin
            n_errors++; $display("FAIL not: res=%h err=%b want FF00 0", res, err);
        end
    endtask

    task automatic test_random_ops();
        logic [15:0] res, a, b; logic err; logic [5:0] f; int w, l, p; bit tmo;
        for (int i = 0; i < 16; i++) begin
            p = $urandom_range(0, 1);
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
            a = 16'($urandom);
            b = 16'($urandom);
            issue_op(p, f, a, b, res, err, w, l, tmo);
            n_checks++;
            if (tmo || w != 0 || l != 2) begin
                n_errors++;
                $display("FAIL rand_timing[%0d]: tmo=%b wait=%0d lat=%0d want 0 0 2", i, tmo, w, l);
            end
            n_checks++;
            if ({err, res} !== {ref_err(f), ref_result(f, a, b)}) begin
                n_errors++;
                $display("FAIL rand_result[%0d]: f=%h got %b %h want %b %h", i, f, err, res,
                         ref_err(f), ref_result(f, a, b));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        reset_n = 1'b0;
        #10;
        reset_n = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_conflict();
        test_bad_func();
        test_reset_mid_op();
        test_shift_logic();
        test_random_ops();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
